// File: rtl/text_cell_tdpram.sv
// Purpose : true-dual-port RAM with byte write enables, backing store for the text-screen controller.
// Latency : port A READ_LATENCY_A clocks (default 2), port B READ_LATENCY_B clocks (default 1).
// Backpres: none; each port accepts one access per clock, so back-to-back reads give full throughput.
// Ports   : clk_i/rst_ni common clock and async active-low reset (output pipeline only);
//           per port x in {a,b}: enx_i enable, wex_i byte write enables, addrx_i word address,
//           dinx_i write data, regcex_i output-register enable (latency 2 only), doutx_o read data.
module text_cell_tdpram #(
  parameter int                    ADDR_WIDTH     = 14,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    READ_LATENCY_A = 2,
  parameter int                    READ_LATENCY_B = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               ena_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wea_i,
  input  logic [ADDR_WIDTH-1:0]              addra_i,
  input  logic [DATA_WIDTH-1:0]              dina_i,
  input  logic                               regcea_i,
  output logic [DATA_WIDTH-1:0]              douta_o,
  input  logic                               enb_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   web_i,
  input  logic [ADDR_WIDTH-1:0]              addrb_i,
  input  logic [DATA_WIDTH-1:0]              dinb_i,
  input  logic                               regceb_i,
  output logic [DATA_WIDTH-1:0]              doutb_o
);

  localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  // Array powers up zeroed; reset never touches it.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic                  wr_a, wr_b, rd_a, rd_b;
  logic [DATA_WIDTH-1:0] wbase_a, wdat_a, wdat_b;
  logic [DATA_WIDTH-1:0] s1a_d, s1a_q, s2a_d, s2a_q;
  logic [DATA_WIDTH-1:0] s1b_d, s1b_q, s2b_d, s2b_q;

  assign wr_a = ena_i && (wea_i != '0);
  assign wr_b = enb_i && (web_i != '0);
  // No-change mode: only a pure read cycle loads stage 1.
  assign rd_a = ena_i && (wea_i == '0);
  assign rd_b = enb_i && (web_i == '0);

  // Whole-word merge per port. When both ports write the same word, port A
  // merges on top of port B's merged word, so A wins overlapping lanes while
  // B's non-overlapping lanes survive the later whole-word store of A.
  always_comb begin
    wdat_b = mem_q[addrb_i];
    for (int k = 0; k < NUM_LANES; k++) begin
      if (web_i[k]) wdat_b[k*BYTE_WIDTH +: BYTE_WIDTH] = dinb_i[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_comb begin
    wbase_a = (wr_b && (addra_i == addrb_i)) ? wdat_b : mem_q[addra_i];
    wdat_a  = wbase_a;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (wea_i[k]) wdat_a[k*BYTE_WIDTH +: BYTE_WIDTH] = dina_i[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_b) mem_q[addrb_i] <= wdat_b;
    if (wr_a) mem_q[addra_i] <= wdat_a;
  end

  // Read pipeline. Stage 1 samples pre-edge contents, which gives
  // read-before-write against a same-edge write from the other port.
  always_comb begin
    s1a_d = s1a_q;
    if (rd_a) s1a_d = mem_q[addra_i];
    s2a_d = s2a_q;
    if (regcea_i) s2a_d = s1a_q;
    s1b_d = s1b_q;
    if (rd_b) s1b_d = mem_q[addrb_i];
    s2b_d = s2b_q;
    if (regceb_i) s2b_d = s1b_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1a_q <= RESET_VALUE;
      s2a_q <= RESET_VALUE;
      s1b_q <= RESET_VALUE;
      s2b_q <= RESET_VALUE;
    end else begin
      s1a_q <= s1a_d;
      s2a_q <= s2a_d;
      s1b_q <= s1b_d;
      s2b_q <= s2b_d;
    end
  end

  // Latency 1 bypasses the output register, so regce has no effect there.
  assign douta_o = (READ_LATENCY_A == 2) ? s2a_q : s1a_q;
  assign doutb_o = (READ_LATENCY_B == 2) ? s2b_q : s1b_q;

endmodule

// File: tb/tb_text_cell_tdpram.sv
module tb_text_cell_tdpram;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int NL    = 4;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena, enb, regcea, regceb;
  logic [NL-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb, douta, doutb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  text_cell_tdpram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
    .READ_LATENCY_A(LAT_A), .READ_LATENCY_B(LAT_B), .RESET_VALUE('0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ena_i(ena), .wea_i(wea), .addra_i(addra), .dina_i(dina), .regcea_i(regcea), .douta_o(douta),
    .enb_i(enb), .web_i(web), .addrb_i(addrb), .dinb_i(dinb), .regceb_i(regceb), .doutb_o(doutb)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory as a plain array; per port the "last word read" and the
  // "word presented at the output" for a latency-2 port.
  logic [DW-1:0] mm [16384];
  logic [DW-1:0] a_last, a_shown, b_last, b_shown;
  logic [DW-1:0] ra, rb;

  always @(negedge rst_n) begin
    a_last = '0; a_shown = '0; b_last = '0; b_shown = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      ra = mm[addra];
      rb = mm[addrb];
      if (regcea) a_shown = a_last;
      if (regceb) b_shown = b_last;
      if (ena && wea == '0) a_last = ra;
      if (enb && web == '0) b_last = rb;
      // B first, then A: A owns overlapping lanes on a same-word collision.
      if (enb) for (int k = 0; k < NL; k++) if (web[k]) mm[addrb][k*8 +: 8] = dinb[k*8 +: 8];
      if (ena) for (int k = 0; k < NL; k++) if (wea[k]) mm[addra][k*8 +: 8] = dina[k*8 +: 8];
    end
  end

  function automatic logic [DW-1:0] exp_a();
    return (LAT_A == 2) ? a_shown : a_last;
  endfunction

  function automatic logic [DW-1:0] exp_b();
    return (LAT_B == 2) ? b_shown : b_last;
  endfunction

  // Compare process: outputs are checked every cycle, mid-cycle.
  always @(negedge clk) begin
    chk("model_douta", douta, exp_a());
    chk("model_doutb", doutb, exp_b());
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    ena = 1'b0; wea = '0; enb = 1'b0; web = '0; regcea = 1'b1; regceb = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic a_op(input logic [NL-1:0] we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    ena = 1'b1; wea = we; addra = ad; dina = d;
  endtask

  task automatic b_op(input logic [NL-1:0] we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    enb = 1'b1; web = we; addrb = ad; dinb = d;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) a = a | 14'h3FF8;
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) mm[i] = '0;
    idle();
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("reset_douta", douta, 32'h0);
    chk("reset_doutb", doutb, 32'h0);

    // Init reads at both ends of the address space.
    rst_n = 1'b1;
    a_op(4'b0000, 14'h0000, '0); b_op(4'b0000, 14'h3FFF, '0);
    tick(); idle();
    chk("init_b_lat1", doutb, 32'h0);
    tick();
    chk("init_a_lat2", douta, 32'h0);

    // Full write on A, then read on both ports.
    a_op(4'b1111, 14'h0100, 32'h12345678);
    tick(); idle();
    a_op(4'b0000, 14'h0100, '0); b_op(4'b0000, 14'h0100, '0);
    tick(); idle();
    chk("full_wr_b", doutb, 32'h12345678);
    tick();
    chk("full_wr_a", douta, 32'h12345678);

    // Byte enables from port B.
    b_op(4'b0101, 14'h0100, 32'hAABBCCDD);
    tick(); idle();
    a_op(4'b0000, 14'h0100, '0);
    tick(); idle(); tick();
    chk("byte_en", douta, 32'h12BB56DD);

    // No-change: a write between read and output stage must not disturb the result.
    a_op(4'b0000, 14'h0200, '0);
    tick(); idle(); tick();
    chk("nc_pre", douta, 32'h0);
    a_op(4'b0000, 14'h0100, '0);
    tick();
    a_op(4'b1111, 14'h0200, 32'hFFFFFFFF);
    tick(); idle(); tick();
    chk("no_change", douta, 32'h12BB56DD);
    a_op(4'b0000, 14'h0200, '0);
    tick(); idle(); tick();
    chk("nc_wr_done", douta, 32'hFFFFFFFF);

    // regce hold on the latency-2 output stage.
    a_op(4'b0000, 14'h0100, '0);
    tick(); idle(); regcea = 1'b0;
    tick();
    chk("regce_hold1", douta, 32'hFFFFFFFF);
    tick();
    chk("regce_hold2", douta, 32'hFFFFFFFF);
    regcea = 1'b1;
    tick();
    chk("regce_load", douta, 32'h12BB56DD);

    // Same-word write collision: A wins.
    a_op(4'b1111, 14'h0300, 32'h11111111); b_op(4'b1111, 14'h0300, 32'h22222222);
    tick(); idle();
    a_op(4'b0000, 14'h0300, '0); b_op(4'b0000, 14'h0300, '0);
    tick(); idle();
    chk("coll_ww_b", doutb, 32'h11111111);
    tick();
    chk("coll_ww_a", douta, 32'h11111111);

    // A writes while B reads the same word: B sees the old contents.
    a_op(4'b1111, 14'h0300, 32'h33333333); b_op(4'b0000, 14'h0300, '0);
    tick(); idle();
    chk("coll_rw_old", doutb, 32'h11111111);
    b_op(4'b0000, 14'h0300, '0);
    tick(); idle();
    chk("coll_rw_new", doutb, 32'h33333333);

    // Partial overlap: A lanes 0,1 ; B lanes 1,2 -> lane1 from A.
    a_op(4'b0011, 14'h0400, 32'hA3A2A1A0); b_op(4'b0110, 14'h0400, 32'hB3B2B1B0);
    tick(); idle();
    b_op(4'b0000, 14'h0400, '0);
    tick(); idle();
    chk("coll_partial", doutb, 32'h00B2A1A0);

    // Async reset between a port A read and its data return.
    a_op(4'b0000, 14'h0300, '0);
    tick(); idle();
    chk("mid_read_pre", douta, 32'h11111111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", douta, 32'h0);
    chk("async_rst_b", doutb, 32'h0);
    tick();
    rst_n = 1'b1;
    a_op(4'b0000, 14'h0300, '0);
    tick(); idle(); tick();
    chk("mem_kept", douta, 32'h33333333);

    // Randomized traffic over a small address window at both ends of memory.
    for (int n = 0; n < 3000; n++) begin
      ena    = ($urandom_range(0, 3) != 0);
      wea    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      addra  = pick_addr();
      dina   = $urandom;
      regcea = ($urandom_range(0, 3) != 0);
      enb    = ($urandom_range(0, 3) != 0);
      web    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      addrb  = ($urandom_range(0, 2) == 0) ? addra : pick_addr();
      dinb   = $urandom;
      regceb = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_cell_tdpram.md
Name: text_cell_tdpram

Overview:
- Single-clock true-dual-port RAM with per-byte write enables; backing store for the text-screen controller.
- Port A: CPU/bus side, 2-cycle read latency.
- Port B: video fetch side, 1-cycle read latency.
- Both ports use no-change write mode. Memory powers up zeroed.

Parameters:
- ADDR_WIDTH, 14, address bits per port; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width for both ports.
- BYTE_WIDTH, 8, bits per write-enable lane; DATA_WIDTH must be a multiple of it.
- READ_LATENCY_A, 2, port A read latency in clocks; legal values 1 or 2.
- READ_LATENCY_B, 1, port B read latency in clocks; legal values 1 or 2.
- RESET_VALUE, 0, value loaded into the output registers by reset.

Ports:
- clk_i  in  1  common clock for both ports, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- ena_i  in  1  port A enable.
- wea_i  in  DATA_WIDTH/BYTE_WIDTH  port A byte write enables.
- addra_i  in  ADDR_WIDTH  port A word address.
- dina_i  in  DATA_WIDTH  port A write data.
- regcea_i  in  1  port A final-output-register clock enable.
- douta_o  out  DATA_WIDTH  port A read data.
- enb_i  in  1  port B enable.
- web_i  in  DATA_WIDTH/BYTE_WIDTH  port B byte write enables.
- addrb_i  in  ADDR_WIDTH  port B word address.
- dinb_i  in  DATA_WIDTH  port B write data.
- regceb_i  in  1  port B final-output-register clock enable.
- doutb_o  out  DATA_WIDTH  port B read data.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - douta_o, doutb_o and all internal read pipeline registers go to RESET_VALUE immediately.
  - Memory array contents are NOT affected.
  - Reads in flight are discarded; release takes effect at the next rising edge.
- Initial memory contents are all zero (array initialized in declaration/initial block).
- Each port is independent and identical except for its latency parameter.
- Write: en=1 and any we bit set at a rising edge.
  - Byte lane k of din (bits k*BYTE_WIDTH+:BYTE_WIDTH) is written to mem[addr] where we[k]=1.
  - Other lanes are preserved.
- No-change mode: a write cycle (any we bit set) does not load the stage-1 read register; the port output keeps its previous value.
- Read: en=1 and we all zero at edge N. mem[addr] (pre-edge contents) is captured in stage 1.
- Latency 1: stage 1 drives dout directly; data is valid after edge N. regce is ignored.
- Latency 2: the output register loads stage 1 at edge N+1 if regce=1; data is valid after edge N+1.
  - With regce=0 the output register holds its value.
  - The stage-1 register only changes on read cycles.
- en=0: no write, no stage-1 update. The latency-2 output stage still obeys regce.
- Back-to-back reads every cycle give full throughput: one result per clock per port.
- Cross-port, same address, same edge:
  - One port writes while the other reads: the reader returns the OLD contents (read-before-write); the write still completes.
  - Both ports write with overlapping enabled lanes: port A data wins on overlapping lanes. Non-overlapping lanes from each port are both written.
  - Different addresses never interact.
- Address is used modulo depth; there are no out-of-range errors.
- Both ports fully synchronous to clk_i; no combinational path from any input to dout.

Test Plan:
- Reset/init:
  - Hold rst_ni=0 → douta_o=doutb_o=0.
  - Release, then read addr 0x0000 and 0x3FFF on both ports → 0 (A after 2 clocks, B after 1).
- Full write then read:
  - Port A writes 0x12345678 to 0x0100 with wea=4'b1111.
  - Port B reads 0x0100 next cycle → doutb_o=0x12345678 one clock later.
  - Port A read → douta_o=0x12345678 two clocks later with regcea=1.
- Byte enables:
  - Port B writes 0xAABBCCDD with web=4'b0101 over 0x12345678 at 0x0100.
  - Port A read → 0x12BB56DD.
- No-change and regce:
  - Port A reads 0x0100, then writes 0xFFFFFFFF to 0x0200 → douta_o stays at the read value.
  - With regcea=0 on the stage-2 cycle → douta_o holds its previous value until regcea=1.
- Collisions:
  - Both ports write 0x0300 the same edge, A=0x11111111 wea=1111, B=0x22222222 web=1111 → readback 0x11111111.
  - A writes 0x33333333 while B reads 0x0300 the same edge → doutb_o returns the old value 0x11111111.
- Async reset mid-read: assert rst_ni low between a port A read and its data return → douta_o=0 immediately; memory contents unchanged on a later read.
